// File: rtl/fetch_pc.sv
// SEQ fetch: PC register, byte-addressed instruction memory and instruction split.
// Decode outputs are combinational from the registered PC; en=0 stalls PC and status.
module fetch_pc #(
    parameter int          MEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC  = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [63:0] newPC,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    output logic [63:0] PC,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic [2:0]  stat
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_e;

    stat_e       stat_q, stat_d;
    logic [63:0] pc_q, pc_d;

    logic [7:0]  mem_q [MEM_BYTES];
    logic [64:0] rd_addr [10];
    logic [7:0]  ib [10];

    logic [3:0]  len;
    logic        has_regs;
    logic        valc_at1;
    logic        valc_at2;
    logic        ins;
    logic        adr;

    always_ff @(posedge clk) begin
        if (imem_we && (imem_waddr < 64'(MEM_BYTES))) begin
            mem_q[imem_waddr[AW-1:0]] <= imem_wdata;
        end
    end

    // Bytes past the end of memory read as zero; the 65-bit address cannot wrap.
    genvar g;
    for (g = 0; g < 10; g++) begin : g_rd
        assign rd_addr[g] = {1'b0, pc_q} + 65'(g);
        assign ib[g]      = (rd_addr[g] < 65'(MEM_BYTES)) ? mem_q[rd_addr[g][AW-1:0]] : 8'h00;
    end

    assign icode = ib[0][7:4];
    assign ifun  = ib[0][3:0];

    always_comb begin
        len      = 4'd1;
        has_regs = 1'b0;
        valc_at1 = 1'b0;
        valc_at2 = 1'b0;
        ins      = 1'b0;
        case (icode)
            4'h0, 4'h1, 4'h9: begin
                len = 4'd1;
                ins = (ifun != 4'h0);
            end
            4'h2: begin
                len      = 4'd2;
                has_regs = 1'b1;
                ins      = (ifun > 4'h6);
            end
            4'h6: begin
                len      = 4'd2;
                has_regs = 1'b1;
                ins      = (ifun > 4'h3);
            end
            4'hA, 4'hB: begin
                len      = 4'd2;
                has_regs = 1'b1;
                ins      = (ifun != 4'h0);
            end
            4'h7: begin
                len      = 4'd9;
                valc_at1 = 1'b1;
                ins      = (ifun > 4'h6);
            end
            4'h8: begin
                len      = 4'd9;
                valc_at1 = 1'b1;
                ins      = (ifun != 4'h0);
            end
            4'h3, 4'h4, 4'h5: begin
                len      = 4'd10;
                has_regs = 1'b1;
                valc_at2 = 1'b1;
                ins      = (ifun != 4'h0);
            end
            default: begin
                len = 4'd1;
                ins = 1'b1;
            end
        endcase
    end

    assign rA = has_regs ? ib[1][7:4] : 4'hF;
    assign rB = has_regs ? ib[1][3:0] : 4'hF;

    always_comb begin
        valC = 64'd0;
        if (valc_at2) begin
            valC = {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]};
        end else if (valc_at1) begin
            valC = {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};
        end
    end

    assign valP = pc_q + 64'(len);

    // Last byte of the instruction must lie inside memory; len >= 1 so no underflow.
    assign adr = (({1'b0, pc_q} + 65'(len) - 65'd1) >= 65'(MEM_BYTES));

    assign instr_valid = (stat_q == S_AOK) && !adr && !ins;

    always_comb begin
        stat_d = stat_q;
        pc_d   = pc_q;
        if (en && (stat_q == S_AOK)) begin
            if (adr) begin
                stat_d = S_ADR;
            end else if (ins) begin
                stat_d = S_INS;
            end else if (icode == 4'h0) begin
                stat_d = S_HLT;
            end else begin
                pc_d = newPC;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            stat_q <= S_AOK;
        end else begin
            pc_q   <= pc_d;
            stat_q <= stat_d;
        end
    end

    assign PC   = pc_q;
    assign stat = stat_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: stimulus pushes expectations, a negedge monitor checks them.
module tb_fetch_pc;

    logic        clk;
    logic        reset;
    logic        en;
    logic [63:0] newPC;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic [63:0] PC;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_valid;
    logic [2:0]  stat;

    fetch_pc #(.MEM_BYTES(1024), .RESET_PC(64'd0)) dut (
        .clk(clk), .reset(reset), .en(en), .newPC(newPC),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .PC(PC), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .instr_valid(instr_valid), .stat(stat)
    );

    typedef struct {
        int          id;
        bit          c_ps;
        logic [63:0] pc;
        logic [2:0]  st;
        bit          c_dec;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        vld;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   next_id  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s (check %0d): got %h want %h", nm, id, act, want);
        end
    endtask

    // Monitor: outputs are combinational, so every pending expectation is checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.c_ps) begin
                    chk("PC",   e.id, PC, e.pc);
                    chk("stat", e.id, 64'(stat), 64'(e.st));
                end
                if (e.c_dec) begin
                    chk("icode", e.id, 64'(icode), 64'(e.icode));
                    chk("ifun",  e.id, 64'(ifun),  64'(e.ifun));
                    chk("rA",    e.id, 64'(rA),    64'(e.ra));
                    chk("rB",    e.id, 64'(rB),    64'(e.rb));
                    chk("valC",  e.id, valC, e.valc);
                    chk("valP",  e.id, valP, e.valp);
                    chk("instr_valid", e.id, 64'(instr_valid), 64'(e.vld));
                end
            end
        end
    end

    task automatic exp_ps(input logic [63:0] pc, input logic [2:0] st);
        exp_t e;
        e = '{default: '0};
        e.id = next_id++; e.c_ps = 1'b1; e.pc = pc; e.st = st;
        sb.push_back(e);
    endtask

    task automatic exp_dec(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                           input logic vld);
        exp_t e;
        e = '{default: '0};
        e.id = next_id++; e.c_dec = 1'b1;
        e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb; e.valc = vc; e.valp = vp; e.vld = vld;
        sb.push_back(e);
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wr(input logic [63:0] a, input logic [7:0] d);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        @(posedge clk); #1;
        imem_we = 1'b0;
    endtask

    task automatic load(input logic [63:0] a, input logic [79:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            wr(a + 64'(i), bytes[79-8*i -: 8]);
        end
    endtask

    task automatic step(input logic [63:0] npc);
        newPC = npc; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; newPC = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_ps(64'd0, 3'd1);
        sample();

        // nop at 0; an out-of-range write to 1024 must not alias onto byte 0
        wr(64'd0, 8'h10);
        wr(64'd1024, 8'hC0);
        exp_dec(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b1);
        sample();
        step(64'h40);
        exp_ps(64'h40, 3'd1);
        sample();

        // asynchronous reset observed before the next rising edge
        @(posedge clk); #2;
        reset = 1'b1;
        exp_ps(64'd0, 3'd1);
        sample();
        @(posedge clk); #1;
        reset = 1'b0;

        load(64'd0, 80'h30F0F0DEBC9A78563412, 10);
        exp_dec(4'h3, 4'h0, 4'hF, 4'h0, 64'h123456789ABCDEF0, 64'd10, 1'b1);
        sample();
        step(64'd10);
        exp_ps(64'd10, 3'd1);
        sample();

        load(64'd10, 80'h80000100000000000000, 9);
        exp_dec(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'd19, 1'b1);
        newPC = 64'h55;
        repeat (3) @(posedge clk);
        #1;
        exp_ps(64'd10, 3'd1);
        sample();

        wr(64'h100, 8'h00);
        step(64'h100);
        exp_ps(64'h100, 3'd1);
        exp_dec(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h101, 1'b1);
        sample();
        step(64'h200);
        exp_ps(64'h100, 3'd2);
        sample();
        newPC = 64'h200; en = 1'b1;
        repeat (5) @(posedge clk);
        #1 en = 1'b0;
        exp_ps(64'h100, 3'd2);
        exp_dec(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h101, 1'b0);
        sample();

        // illegal icode
        do_reset();
        wr(64'd0, 8'hC0);
        exp_dec(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0);
        sample();
        step(64'h77);
        exp_ps(64'd0, 3'd4);
        sample();

        // OPq with ifun 5; byte 1 still holds F0 from the irmovq
        do_reset();
        wr(64'd0, 8'h65);
        exp_ps(64'd0, 3'd1);
        exp_dec(4'h6, 4'h5, 4'hF, 4'h0, 64'd0, 64'd2, 1'b0);
        sample();
        step(64'h77);
        exp_ps(64'd0, 3'd4);
        sample();

        // write to the byte at PC on a step edge: the step sees the old 65
        do_reset();
        imem_we = 1'b1; imem_waddr = 64'd0; imem_wdata = 8'h10;
        newPC = 64'h30; en = 1'b1;
        @(posedge clk); #1;
        imem_we = 1'b0; en = 1'b0;
        exp_ps(64'd0, 3'd4);
        exp_dec(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0);
        sample();

        // irmovq straddling the end of memory
        do_reset();
        load(64'd1020, 80'h30F01122000000000000, 4);
        step(64'd1020);
        exp_ps(64'd1020, 3'd1);
        exp_dec(4'h3, 4'h0, 4'hF, 4'h0, 64'h2211, 64'd1030, 1'b0);
        sample();
        step(64'd5);
        exp_ps(64'd1020, 3'd3);
        sample();
        do_reset();
        exp_ps(64'd0, 3'd1);
        sample();

        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
